// File: rtl/dcache_pkg.sv
// Shared types and line geometry for the L1 data cache.
// Used by the controller FSM and its word counter.
package dcache_pkg;

  typedef enum logic [1:0] {
    LOAD,
    STORE,
    CLFLUSH
  } memory_operation_e;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } dcache_state_e;

  function automatic int unsigned words_per_line(int unsigned line_size, int unsigned xlen);
    return line_size / (xlen / 8);
  endfunction

  localparam int unsigned WORDS = words_per_line(32, 32);

endpackage

// File: rtl/dcache_word_counter.sv
// Beat counter for line writeback/refill; wraps at WORDS-1 and flags the last beat.
module dcache_word_counter #(
  parameter int unsigned WORDS = 8,
  localparam int unsigned W    = $clog2(WORDS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q;

  assign last_o  = (count_q == W'(WORDS - 1));
  assign count_o = count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Sequencing FSM for the direct-mapped write-back L1 D-cache: hit handling,
// dirty writeback and refill one L2 word per beat, pipeline acknowledge.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 32,
  parameter int unsigned XLEN      = 32
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             pipe_req_valid,
  input  memory_operation_e                                pipe_req_type,
  output logic                                             pipe_word_valid,
  input  logic                                             hit,
  input  logic                                             dirty,
  output logic [$clog2(words_per_line(LINE_SIZE, XLEN))-1:0] word_idx,
  output logic                                             victim_sel,
  output logic                                             fill_we,
  output logic                                             store_we,
  output logic                                             tag_we,
  output logic                                             valid_clr,
  output logic                                             dirty_set,
  output logic                                             dirty_clr,
  output logic                                             l2_access,
  output logic                                             l2_write,
  input  logic                                             l2_word_valid
);

  localparam int unsigned N_WORDS = words_per_line(LINE_SIZE, XLEN);

  dcache_state_e state_q;
  logic          last_word;
  logic          beat;

  assign beat = l2_word_valid && (state_q == WRITEBACK || state_q == ALLOCATE);

  // Every exit from COMPARE into a line transfer starts at word 0.
  dcache_word_counter #(.WORDS(N_WORDS)) u_word_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q == COMPARE),
    .en_i    (beat),
    .count_o (word_idx),
    .last_o  (last_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (pipe_req_valid) state_q <= COMPARE;
        COMPARE: begin
          if (hit) begin
            state_q <= (pipe_req_type == CLFLUSH && dirty) ? WRITEBACK : IDLE;
          end else if (pipe_req_type == CLFLUSH) begin
            state_q <= IDLE;
          end else begin
            state_q <= dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (l2_word_valid && last_word)
          state_q <= (pipe_req_type == CLFLUSH) ? IDLE : ALLOCATE;
        ALLOCATE: if (l2_word_valid && last_word) state_q <= COMPARE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pipe_word_valid = 1'b0;
    victim_sel      = 1'b0;
    fill_we         = 1'b0;
    store_we        = 1'b0;
    tag_we          = 1'b0;
    valid_clr       = 1'b0;
    dirty_set       = 1'b0;
    dirty_clr       = 1'b0;
    l2_access       = 1'b0;
    l2_write        = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (hit) begin
          unique case (pipe_req_type)
            LOAD: pipe_word_valid = 1'b1;
            STORE: begin
              store_we        = 1'b1;
              dirty_set       = 1'b1;
              pipe_word_valid = 1'b1;
            end
            CLFLUSH: if (!dirty) begin
              valid_clr       = 1'b1;
              pipe_word_valid = 1'b1;
            end
            default: ;
          endcase
        end else if (pipe_req_type == CLFLUSH) begin
          pipe_word_valid = 1'b1;
        end
      end
      WRITEBACK: begin
        l2_access  = 1'b1;
        l2_write   = 1'b1;
        victim_sel = 1'b1;
        if (l2_word_valid && last_word && pipe_req_type == CLFLUSH) begin
          dirty_clr       = 1'b1;
          valid_clr       = 1'b1;
          pipe_word_valid = 1'b1;
        end
      end
      ALLOCATE: begin
        l2_access = 1'b1;
        fill_we   = l2_word_valid;
        if (l2_word_valid && last_word) begin
          tag_we    = 1'b1;
          dirty_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a 4-set tag/valid/dirty model and
// an L2 responder drive the FSM; expected enable events are queued per request.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  memory_operation_e req_type;
  logic              pipe_word_valid;
  logic              hit, dirty;
  logic [2:0]        word_idx;
  logic              victim_sel, fill_we, store_we, tag_we, valid_clr;
  logic              dirty_set, dirty_clr, l2_access, l2_write;
  logic              l2_word_valid;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk             (clk),
    .reset           (reset),
    .pipe_req_valid  (req_valid),
    .pipe_req_type   (req_type),
    .pipe_word_valid (pipe_word_valid),
    .hit             (hit),
    .dirty           (dirty),
    .word_idx        (word_idx),
    .victim_sel      (victim_sel),
    .fill_we         (fill_we),
    .store_we        (store_we),
    .tag_we          (tag_we),
    .valid_clr       (valid_clr),
    .dirty_set       (dirty_set),
    .dirty_clr       (dirty_clr),
    .l2_access       (l2_access),
    .l2_write        (l2_write),
    .l2_word_valid   (l2_word_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Datapath model: set and tag of the current request select the stored line.
  logic [1:0] req_set;
  logic [8:0] req_tag;
  logic [8:0] tag_m   [4];
  logic       valid_m [4];
  logic       dirty_m [4];
  logic       pre_en, pre_valid, pre_dirty;
  logic [1:0] pre_set;
  logic [8:0] pre_tag;

  always @(posedge clk) begin
    if (pre_en) begin
      tag_m[pre_set]   <= pre_tag;
      valid_m[pre_set] <= pre_valid;
      dirty_m[pre_set] <= pre_dirty;
    end else begin
      if (tag_we) begin
        tag_m[req_set]   <= req_tag;
        valid_m[req_set] <= 1'b1;
      end
      if (valid_clr) valid_m[req_set] <= 1'b0;
      if (dirty_set) dirty_m[req_set] <= 1'b1;
      if (dirty_clr) dirty_m[req_set] <= 1'b0;
    end
  end

  assign hit   = valid_m[req_set] && (tag_m[req_set] == req_tag);
  assign dirty = dirty_m[req_set];

  // L2 responder: each beat completes two cycles after the previous one.
  logic l2_resp, l2_manual, l2_force;
  int   l2_cnt;

  always @(posedge clk) begin
    if (reset || !l2_access) begin
      l2_resp <= 1'b0;
      l2_cnt  <= 0;
    end else if (l2_resp) begin
      l2_resp <= 1'b0;
      l2_cnt  <= 0;
    end else if (l2_cnt == 1) begin
      l2_resp <= 1'b1;
    end else begin
      l2_cnt <= l2_cnt + 1;
    end
  end

  assign l2_word_valid = l2_manual ? l2_force : l2_resp;

  // Scoreboard of enable events.
  logic [12:0] exp_q[$];
  logic [12:0] obs;
  logic        ev_trig;
  logic [9:0]  outs_vec;

  assign obs = {pipe_word_valid, fill_we, store_we, tag_we, valid_clr, dirty_set,
                dirty_clr, l2_access, l2_write, victim_sel, word_idx};
  assign ev_trig = pipe_word_valid | fill_we | store_we | tag_we | valid_clr |
                   dirty_set | dirty_clr | (l2_access & l2_word_valid);
  assign outs_vec = {pipe_word_valid, victim_sel, fill_we, store_we, tag_we,
                     valid_clr, dirty_set, dirty_clr, l2_access, l2_write};

  always @(negedge clk) begin
    if (ev_trig) begin
      if (exp_q.size() == 0) check("sb_extra", 32'(obs), 32'h0);
      else                   check("sb_event", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [12:0] ev(bit ack, bit fill, bit store, bit tag, bit vclr,
                                     bit dset, bit dclr, bit acc, bit wr, bit vsel, int idx);
    return {ack, fill, store, tag, vclr, dset, dclr, acc, wr, vsel, 3'(idx)};
  endfunction

  task automatic push_fills(int n);
    for (int i = 0; i < n; i++) begin
      bit l;
      l = (i == 7);
      exp_q.push_back(ev(0, 1, 0, l, 0, 0, l, 1, 0, 0, i));
    end
  endtask

  task automatic push_wbs(bit flush);
    for (int i = 0; i < 8; i++) begin
      bit l;
      l = flush && (i == 7);
      exp_q.push_back(ev(l, 0, 0, 0, l, 0, l, 1, 1, 1, i));
    end
  endtask

  task automatic preload(logic [1:0] s, logic [8:0] t, logic v, logic d);
    @(posedge clk); #1;
    pre_set = s; pre_tag = t; pre_valid = v; pre_dirty = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_req(memory_operation_e op, logic [1:0] s, logic [8:0] t,
                        string tag, int exp_lat);
    int  n;
    bit  got;
    @(posedge clk); #1;
    req_type = op; req_set = s; req_tag = t; req_valid = 1'b1;
    got = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pipe_word_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_lat"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    reset = 1'b1; req_valid = 1'b0; req_type = LOAD; req_set = '0; req_tag = '0;
    l2_manual = 1'b0; l2_force = 1'b0;
    pre_en = 1'b0; pre_set = '0; pre_tag = '0; pre_valid = 1'b0; pre_dirty = 1'b0;
    for (int s = 0; s < 4; s++) preload(2'(s), 9'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_outs", 32'(outs_vec), 32'h0);
    check("rst_idx", 32'(word_idx), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Stray L2 completions while idle must be ignored.
    @(posedge clk); #1;
    l2_manual = 1'b1; l2_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_l2_outs", 32'(outs_vec), 32'h0);
      check("idle_l2_idx", 32'(word_idx), 32'h0);
    end
    @(posedge clk); #1;
    l2_manual = 1'b0; l2_force = 1'b0;
    check("idle_l2_state", 32'(dut.state_q), 32'(IDLE));

    // Set 0 holds tag 0, valid and clean.
    preload(2'd0, 9'h000, 1'b1, 1'b0);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_req(LOAD, 2'd0, 9'h000, "load_hit", 1);

    exp_q.push_back(ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    do_req(STORE, 2'd0, 9'h000, "store_hit", 1);

    push_fills(8);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_req(LOAD, 2'd1, 9'h000, "load_miss", 26);

    // Set 0 is dirty with tag 0; a store to tag 1 evicts it.
    push_wbs(1'b0);
    push_fills(8);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    do_req(STORE, 2'd0, 9'h001, "store_dirty_miss", 50);

    push_wbs(1'b1);
    do_req(CLFLUSH, 2'd0, 9'h001, "flush_dirty", 25);
    check("flush_state", 32'(dut.state_q), 32'(IDLE));

    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_req(CLFLUSH, 2'd0, 9'h001, "flush_miss", 1);

    exp_q.push_back(ev(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    do_req(CLFLUSH, 2'd1, 9'h000, "flush_clean", 1);

    // Reset in the middle of a refill abandons it.
    push_fills(4);
    @(posedge clk); #1;
    req_type = LOAD; req_set = 2'd2; req_tag = 9'h005; req_valid = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fill_we && word_idx == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_alloc_reach", 32'(found), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_alloc_outs", 32'(outs_vec), 32'h0);
    check("rst_alloc_idx", 32'(word_idx), 32'h0);
    check("rst_alloc_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_alloc_drain", 32'(exp_q.size()), 32'h0);

    push_fills(8);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_req(LOAD, 2'd2, 9'h005, "reload_miss", 26);

    repeat (3) @(negedge clk);
    check("sb_final", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Sequencing FSM for the direct-mapped, write-back L1 data cache. It sits inside `dcache` between the pipeline request port, the cache datapath (tag/valid/dirty/data arrays) and the L2 word interface. It decides hit/miss handling, runs dirty-line writeback and line refill one word at a time, and acknowledges the pipeline. It holds no cache data; it only drives datapath enables and L2 handshakes.

## Interface

Parameters:
- `LINE_SIZE`, 32: bytes per line.
- `XLEN`, 32: bits per word; words per line `WORDS = LINE_SIZE/(XLEN/8)` (8 by default).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `pipe_req_valid` in 1: pipeline request present; held with `pipe_req_*` stable until `pipe_word_valid`.
- `pipe_req_type` in `memory_operation_e`: LOAD, STORE, CLFLUSH.
- `pipe_word_valid` out 1: one-cycle completion or ack to the pipeline.
- `hit` in 1: from the datapath; tag match and valid, for the addressed set.
- `dirty` in 1: from the datapath; dirty bit of the addressed set.
- `word_idx` out `$clog2(WORDS)`: word index the datapath uses for L2 address and data muxing.
- `victim_sel` out 1: 1 means the datapath forms `l2_address` from the stored tag (writeback); 0 means from the request tag.
- `fill_we` out 1: write `l2_word` into the data array at `word_idx`.
- `store_we` out 1: write the pipeline store data (size-masked by the datapath).
- `tag_we` out 1: load the request tag and set valid.
- `valid_clr` out 1: clear valid (flush).
- `dirty_set` out 1: set the dirty bit.
- `dirty_clr` out 1: clear the dirty bit.
- `l2_access` out 1: L2 request active.
- `l2_write` out 1: 1 means L2 write of the datapath word; 0 means read.
- `l2_word_valid` in 1: L2 per-word completion; ignored while `l2_access=0`.

## Operation

States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: when `pipe_req_valid`, go to COMPARE. Otherwise stay.
- COMPARE, LOAD hit: `pipe_word_valid=1`, go to IDLE.
- COMPARE, STORE hit: `store_we=1`, `dirty_set=1`, `pipe_word_valid=1`, go to IDLE.
- COMPARE, CLFLUSH hit and clean, or CLFLUSH miss: `valid_clr=1` only on hit; `pipe_word_valid=1`; go to IDLE.
- COMPARE, CLFLUSH hit and dirty: go to WRITEBACK.
- COMPARE, LOAD/STORE miss and dirty: go to WRITEBACK.
- COMPARE, LOAD/STORE miss and clean: go to ALLOCATE.
- WRITEBACK: `l2_access=1`, `l2_write=1`, `victim_sel=1`. Advance `word_idx` on each `l2_word_valid`. On the last word (`WORDS-1`):
  - CLFLUSH: `dirty_clr=1`, `valid_clr=1`, `pipe_word_valid=1`, go to IDLE.
  - otherwise: go to ALLOCATE.
- ALLOCATE: `l2_access=1`, `l2_write=0`. Each `l2_word_valid` asserts `fill_we` and advances `word_idx`. On the last word: `tag_we=1`, `dirty_clr=1`, go to COMPARE. The replayed compare then hits.
- Word counter: cleared on every entry to WRITEBACK or ALLOCATE. It wraps from `WORDS-1` to 0.
- All outputs are decoded combinationally from state, `hit`, `dirty`, `pipe_req_type` and `l2_word_valid`. Nothing is asserted in IDLE.

## Timing

- Reset: state=IDLE, `word_idx=0`, every output 0 from the cycle after `reset` is sampled high.
- Reset mid-WRITEBACK or mid-ALLOCATE: the transaction is abandoned and `l2_access` drops. The line stays in its prior tag/valid/dirty state because `tag_we` was not issued.
- Hit latency: request seen in IDLE at cycle 0; `pipe_word_valid` at cycle 1.
- Clean miss: 1 (COMPARE) + `WORDS` L2 beats + 1 (replay COMPARE).
- Dirty miss: adds `WORDS` writeback beats.
- An L2 beat ends in the cycle `l2_word_valid=1`. `l2_access` stays high across back-to-back beats of one line.
- `pipe_req_valid` is ignored outside IDLE.
- A new request may be accepted in the cycle after `pipe_word_valid`.

## Structure

- Put these in `dcache_pkg`: `memory_operation_e`, `memory_operation_size_e`, `dcache_state_e`, and the `WORDS` localparam function.
- Sub-module `dcache_word_counter`: clear/enable, wrapping counter with a `last` flag.
- `dcache` top instantiates `dcache_controller` and the datapath.

## Test plan

- LOAD hit, set preloaded valid: `pipe_word_valid` high exactly at cycle 1; no `l2_access`.
- LOAD clean miss, L2 answers each beat after 2 cycles: 8 `fill_we` pulses with `word_idx` 0..7, `tag_we` on the last beat, then `pipe_word_valid` on the replay COMPARE.
- STORE to a dirty line with a different tag: 8 write beats with `victim_sel=1`, then 8 read beats, then `store_we` and `dirty_set` on the replay.
- CLFLUSH on a dirty hit: 8 writeback beats, then `valid_clr`, `dirty_clr` and `pipe_word_valid` together; return to IDLE.
- `reset` at ALLOCATE beat 4: next cycle all outputs 0 and state IDLE; a following LOAD to the same address misses again.
- `l2_word_valid` pulsed while IDLE: no state change and no enables.
